// File: rtl/dice_regs_pkg.sv
// Shared constants, register map and FSM encoding for the dice register bank.
package dice_regs_pkg;

    // Register map
    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_CTRL     = 8'h01;
    localparam logic [7:0] ADDR_SIDES    = 8'h02;
    localparam logic [7:0] ADDR_COUNT    = 8'h03;
    localparam logic [7:0] ADDR_STATUS   = 8'h04;
    localparam logic [7:0] ADDR_RESULT_L = 8'h05;
    localparam logic [7:0] ADDR_RESULT_H = 8'h06;
    localparam logic [7:0] ADDR_SEED     = 8'h07;

    localparam logic [7:0]  ID_VAL     = 8'hD6;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] LFSR_INIT  = 16'h00A5;
    localparam logic [7:0]  SEED_LOW   = 8'hA5;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    // Roll engine states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAW   = 2'd1,
        ST_REDUCE = 2'd2,
        ST_ACCUM  = 2'd3
    } dice_state_t;

    // One Galois right-shift step of the LFSR
    function automatic logic [15:0] lfsr_next(input logic [15:0] l, input logic [15:0] taps);
        return (l >> 1) ^ (l[0] ? taps : 16'h0000);
    endfunction

endpackage

// File: rtl/dice_lfsr16.sv
// 16-bit Galois LFSR with synchronous load; advances one step when step is high.
module dice_lfsr16
    import dice_regs_pkg::*;
#(
    parameter logic [15:0] TAPS = dice_regs_pkg::LFSR_TAPS
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] q
);

    // LFSR register: load has priority over step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_INIT;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= lfsr_next(q, TAPS);
        end
    end

endmodule

// File: rtl/i2c_dice_regs.sv
// Register bank and dice roll engine behind the I2C slave application interface.
// Interface semantics: wen qualifies addr/wdata for exactly one cycle (no back-pressure);
// rdata is a registered view of addr with one cycle of latency; rdata_used is a one-cycle
// notification that the slave has consumed rdata for the current addr.
module i2c_dice_regs
    import dice_regs_pkg::*;
#(
    parameter logic [7:0]  ID_VAL    = dice_regs_pkg::ID_VAL,
    parameter int          MAX_DICE  = 8,
    parameter logic [15:0] LFSR_TAPS = dice_regs_pkg::LFSR_TAPS
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic       wen,
    input  logic [7:0] wdata,
    input  logic       rdata_used,
    output logic [7:0] rdata,
    output logic       irq
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DICE);

    // Transfer direction is informational only
    logic unused_rw;
    assign unused_rw = rw;

    dice_state_t state, state_nxt;

    logic        irq_en, irq_en_nxt;
    logic        done, done_nxt;
    logic        err;
    logic [7:0]  sides_r;
    logic [3:0]  count_r;
    logic [10:0] result;

    // Engine shadow state, latched at START
    logic [7:0]  eng_sides;
    logic [3:0]  eng_cnt;
    logic [7:0]  rem;
    logic [10:0] sum_acc;
    logic [10:0] sum_new;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_nxt;
    logic [7:0]  rdata_mux;

    logic busy;
    logic wr_ctrl;
    logic start_req;
    logic roll_ok;
    logic start_go;
    logic start_bad;
    logic seed_load;
    logic reduce_sub;
    logic roll_last;

    assign busy       = (state != ST_IDLE);
    assign wr_ctrl    = wen && (addr == ADDR_CTRL);
    assign start_req  = wr_ctrl && wdata[CTRL_START] && !busy;
    assign roll_ok    = (sides_r >= 8'd2) && (count_r != 4'd0) && (count_r <= MAX_CNT);
    assign start_go   = start_req && roll_ok;
    assign start_bad  = start_req && !roll_ok;
    assign seed_load  = wen && (addr == ADDR_SEED) && !busy;
    assign reduce_sub = (state == ST_REDUCE) && (rem >= eng_sides);
    assign roll_last  = (state == ST_ACCUM) && (eng_cnt == 4'd1);
    assign lfsr_nxt   = lfsr_next(lfsr_q, LFSR_TAPS);
    assign sum_new    = sum_acc + {3'b000, rem} + 11'd1;

    dice_lfsr16 #(
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_load),
        .load_val ({wdata, SEED_LOW}),
        .step     (state == ST_DRAW),
        .q        (lfsr_q)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: draw, reduce modulo sides, accumulate, repeat per die
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_go) state_nxt = ST_DRAW;
            ST_DRAW:   state_nxt = ST_REDUCE;
            ST_REDUCE: if (!reduce_sub) state_nxt = ST_ACCUM;
            ST_ACCUM:  state_nxt = roll_last ? ST_IDLE : ST_DRAW;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Host-writable configuration registers (writable even while a roll runs)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sides_r <= 8'h00;
            count_r <= 4'h0;
        end else if (wen) begin
            if (addr == ADDR_SIDES) sides_r <= wdata;
            if (addr == ADDR_COUNT) count_r <= wdata[3:0];
        end
    end

    // Roll engine datapath; RESULT only changes when the last die is accumulated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_sides <= 8'h00;
            eng_cnt   <= 4'h0;
            rem       <= 8'h00;
            sum_acc   <= 11'h000;
            result    <= 11'h000;
        end else begin
            if (start_go) begin
                eng_sides <= sides_r;
                eng_cnt   <= count_r;
                sum_acc   <= 11'h000;
            end
            case (state)
                ST_DRAW:   rem <= lfsr_nxt[7:0];
                ST_REDUCE: if (reduce_sub) rem <= rem - eng_sides;
                ST_ACCUM: begin
                    sum_acc <= sum_new;
                    eng_cnt <= eng_cnt - 4'd1;
                    if (roll_last) result <= sum_new;
                end
                default: ;
            endcase
        end
    end

    // Next values of DONE and IRQ_EN; a completing roll beats a same-cycle clear
    always_comb begin
        done_nxt = done;
        if (rdata_used && (addr == ADDR_RESULT_L)) done_nxt = 1'b0;
        if (start_req) done_nxt = 1'b0;
        if (roll_last) done_nxt = 1'b1;
        irq_en_nxt = wr_ctrl ? wdata[CTRL_IRQ_EN] : irq_en;
    end

    // Status flags and interrupt enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            err    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            done   <= done_nxt;
            irq_en <= irq_en_nxt;
            if (start_bad) begin
                err <= 1'b1;
            end else if (start_go) begin
                err <= 1'b0;
            end
        end
    end

    // Read mux; unmapped and write-only addresses read zero
    always_comb begin
        rdata_mux = 8'h00;
        case (addr)
            ADDR_ID:       rdata_mux = ID_VAL;
            ADDR_CTRL:     rdata_mux = {6'b0, irq_en, 1'b0};
            ADDR_SIDES:    rdata_mux = sides_r;
            ADDR_COUNT:    rdata_mux = {4'b0, count_r};
            ADDR_STATUS:   rdata_mux = {5'b0, err, done, busy};
            ADDR_RESULT_L: rdata_mux = result[7:0];
            ADDR_RESULT_H: rdata_mux = {5'b0, result[10:8]};
            default:       rdata_mux = 8'h00;
        endcase
    end

    // Registered read data and interrupt (irq tracks DONE with no extra lag)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
            irq   <= 1'b0;
        end else begin
            rdata <= rdata_mux;
            irq   <= irq_en_nxt & done_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_dice_regs.sv
// Directed bench for the dice register bank: register-map vector table plus roll sequences.
module tb_i2c_dice_regs;

    logic       clk;
    logic       rst_n;
    logic       rw;
    logic [7:0] addr;
    logic       wen;
    logic [7:0] wdata;
    logic       rdata_used;
    logic [7:0] rdata;
    logic       irq;

    int checks = 0;
    int errors = 0;

    // Expected roll results, pushed before a roll and popped when it is checked
    logic [7:0] exp_q[$];

    typedef struct {
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    i2c_dice_regs u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rw         (rw),
        .addr       (addr),
        .wen        (wen),
        .wdata      (wdata),
        .rdata_used (rdata_used),
        .rdata      (rdata),
        .irq        (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        rw    = 1'b0;
        wen   = 1'b1;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a;
        rw   = 1'b1;
        @(negedge clk);
        d = rdata;
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        do_read(a, d);
        check(name, {8'h00, d}, {8'h00, exp});
    endtask

    // Poll STATUS each cycle until DONE shows; n is the number of cycles waited
    task automatic wait_done(input int budget, output int n);
        logic found;
        found = 1'b0;
        addr  = 8'h04;
        n     = 0;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            if (rdata[1]) found = 1'b1;
        end
        check("done_timeout", {15'h0, found}, 16'h0001);
    endtask

    task automatic setup_roll(input logic [7:0] seed, input logic [7:0] sides, input logic [7:0] count);
        do_write(8'h07, seed);
        do_write(8'h02, sides);
        do_write(8'h03, count);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [7:0] d;
        int n;
        int busy_seen;

        rst_n = 1'b0; rw = 1'b0; addr = 8'h00; wen = 1'b0; wdata = 8'h00; rdata_used = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("irq_reset", {15'h0, irq}, 16'h0000);
        check("rdata_reset", {8'h00, rdata}, 16'h0000);

        // Register map vectors
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'hD6, "rst_id"});
        vecs.push_back('{1'b0, 8'h01, 8'h00, 8'h00, "rst_ctrl"});
        vecs.push_back('{1'b0, 8'h02, 8'h00, 8'h00, "rst_sides"});
        vecs.push_back('{1'b0, 8'h03, 8'h00, 8'h00, "rst_count"});
        vecs.push_back('{1'b0, 8'h04, 8'h00, 8'h00, "rst_status"});
        vecs.push_back('{1'b0, 8'h05, 8'h00, 8'h00, "rst_res_l"});
        vecs.push_back('{1'b0, 8'h06, 8'h00, 8'h00, "rst_res_h"});
        vecs.push_back('{1'b0, 8'h07, 8'h00, 8'h00, "rst_seed"});
        vecs.push_back('{1'b0, 8'h08, 8'h00, 8'h00, "unmapped_08"});
        vecs.push_back('{1'b0, 8'hFF, 8'h00, 8'h00, "unmapped_ff"});
        vecs.push_back('{1'b1, 8'h02, 8'h5A, 8'h00, "wr_sides"});
        vecs.push_back('{1'b0, 8'h02, 8'h00, 8'h5A, "rd_sides"});
        vecs.push_back('{1'b1, 8'h03, 8'hFF, 8'h00, "wr_count"});
        vecs.push_back('{1'b0, 8'h03, 8'h00, 8'h0F, "rd_count"});
        vecs.push_back('{1'b1, 8'h01, 8'h02, 8'h00, "wr_irq_en"});
        vecs.push_back('{1'b0, 8'h01, 8'h00, 8'h02, "rd_irq_en"});
        vecs.push_back('{1'b1, 8'h00, 8'h12, 8'h00, "wr_id"});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'hD6, "rd_id_ro"});
        vecs.push_back('{1'b1, 8'h04, 8'hFF, 8'h00, "wr_status"});
        vecs.push_back('{1'b0, 8'h04, 8'h00, 8'h00, "rd_status_ro"});
        vecs.push_back('{1'b1, 8'h05, 8'h77, 8'h00, "wr_res_l"});
        vecs.push_back('{1'b0, 8'h05, 8'h00, 8'h00, "rd_res_l_ro"});
        vecs.push_back('{1'b1, 8'h08, 8'h33, 8'h00, "wr_unmapped"});
        vecs.push_back('{1'b0, 8'h08, 8'h00, 8'h00, "rd_unmapped"});
        vecs.push_back('{1'b1, 8'h07, 8'h5C, 8'h00, "wr_seed"});
        vecs.push_back('{1'b0, 8'h07, 8'h00, 8'h00, "rd_seed_wo"});
        vecs.push_back('{1'b1, 8'h01, 8'h00, 8'h00, "clr_irq_en"});
        vecs.push_back('{1'b0, 8'h01, 8'h00, 8'h00, "rd_ctrl_clr"});

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].a, vecs[i].d);
            end else begin
                read_check(vecs[i].name, vecs[i].a, vecs[i].exp);
            end
        end
        check("irq_after_map", {15'h0, irq}, 16'h0000);

        // Single die, d6, seed 00: draw 0x52 = 82, 82 mod 6 = 4 -> 5
        exp_q.push_back(8'h05);
        setup_roll(8'h00, 8'h06, 8'h01);
        do_write(8'h01, 8'h01);
        addr = 8'h04;
        @(negedge clk);
        check("busy_set", {8'h00, rdata}, 16'h0001);
        wait_done(60, n);
        check("done_within_17", {15'h0, (n + 1) <= 17}, 16'h0001);
        check("lfsr_one_draw", u_dut.lfsr_q, 16'hB452);
        read_check("roll1_res_l", 8'h05, exp_q.pop_front());
        read_check("roll1_res_h", 8'h06, 8'h00);
        read_check("roll1_status", 8'h04, 8'h02);
        check("roll1_irq_off", {15'h0, irq}, 16'h0000);

        // Two dice: draws 0x52 (->5) and 0x29 = 41 (->6), sum 11
        exp_q.push_back(8'h0B);
        setup_roll(8'h00, 8'h06, 8'h02);
        do_write(8'h01, 8'h01);
        wait_done(80, n);
        read_check("roll2_res_l", 8'h05, exp_q.pop_front());
        read_check("roll2_res_h", 8'h06, 8'h00);
        check("lfsr_two_draws", u_dut.lfsr_q, 16'h5A29);

        // Illegal configurations set ERR and never start a roll
        setup_roll(8'h00, 8'h01, 8'h01);
        do_write(8'h01, 8'h01);
        addr = 8'h04;
        busy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rdata[0]) busy_seen++;
        end
        check("err_sides1_nobusy", 16'(busy_seen), 16'h0000);
        read_check("err_sides1_status", 8'h04, 8'h04);
        read_check("err_result_kept", 8'h05, 8'h0B);
        setup_roll(8'h00, 8'h06, 8'h00);
        do_write(8'h01, 8'h01);
        read_check("err_count0_status", 8'h04, 8'h04);
        do_write(8'h03, 8'h09);
        do_write(8'h01, 8'h01);
        read_check("err_count9_status", 8'h04, 8'h04);
        do_write(8'h03, 8'h08);
        read_check("count8_readback", 8'h03, 8'h08);

        // IRQ path, d20: 82 mod 20 = 2 -> 3; second START while busy is ignored
        exp_q.push_back(8'h03);
        do_write(8'h01, 8'h02);
        setup_roll(8'h00, 8'h14, 8'h01);
        do_write(8'h01, 8'h03);
        do_write(8'h01, 8'h03);
        wait_done(60, n);
        check("irq_set", {15'h0, irq}, 16'h0001);
        read_check("roll3_res_l", 8'h05, exp_q.pop_front());
        read_check("roll3_status", 8'h04, 8'h02);
        repeat (20) @(negedge clk);
        check("single_roll_lfsr", u_dut.lfsr_q, 16'hB452);
        read_check("single_roll_status", 8'h04, 8'h02);
        @(negedge clk);
        addr = 8'h05;
        rdata_used = 1'b1;
        @(negedge clk);
        rdata_used = 1'b0;
        check("irq_cleared", {15'h0, irq}, 16'h0000);
        read_check("done_cleared", 8'h04, 8'h00);

        // Asynchronous reset in the middle of REDUCE
        setup_roll(8'h00, 8'h06, 8'h01);
        do_write(8'h01, 8'h03);
        addr = 8'h00;
        repeat (6) @(negedge clk);
        check("pre_reset_id", {8'h00, rdata}, 16'h00D6);
        #2 rst_n = 1'b0;
        #1;
        check("async_rdata", {8'h00, rdata}, 16'h0000);
        check("async_irq", {15'h0, irq}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("post_rst_id", 8'h00, 8'hD6);
        read_check("post_rst_ctrl", 8'h01, 8'h00);
        read_check("post_rst_status", 8'h04, 8'h00);
        read_check("post_rst_res_l", 8'h05, 8'h00);
        exp_q.push_back(8'h05);
        setup_roll(8'h00, 8'h06, 8'h01);
        do_write(8'h01, 8'h01);
        wait_done(60, n);
        read_check("post_rst_roll", 8'h05, exp_q.pop_front());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
